// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: bit order, blank pattern and hex glyphs.
// All patterns are active-low; a 0 bit lights the segment.
package seg_pkg;

  typedef logic [6:0] seg_t;

  // Bit order of every seg_t: seg[6:0] = {g,f,e,d,c,b,a}
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  localparam seg_t SEG_OFF = 7'h7F;

  localparam seg_t GLYPH_0 = 7'h40;
  localparam seg_t GLYPH_1 = 7'h79;
  localparam seg_t GLYPH_2 = 7'h24;
  localparam seg_t GLYPH_3 = 7'h30;
  localparam seg_t GLYPH_4 = 7'h19;
  localparam seg_t GLYPH_5 = 7'h12;
  localparam seg_t GLYPH_6 = 7'h02;
  localparam seg_t GLYPH_7 = 7'h78;
  localparam seg_t GLYPH_8 = 7'h00;
  localparam seg_t GLYPH_9 = 7'h10;
  localparam seg_t GLYPH_A = 7'h08;
  localparam seg_t GLYPH_B = 7'h03;
  localparam seg_t GLYPH_C = 7'h46;
  localparam seg_t GLYPH_D = 7'h21;
  localparam seg_t GLYPH_E = 7'h06;
  localparam seg_t GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg_scan_display_if.sv
// Host-side bus of the scan display: display word, masks, load strobe and status.
// The host (master) drives data and load; the display (slave) returns busy and frame_tick.
interface seg_scan_display_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data_in;
  logic                load;
  logic                blank_lz;
  logic [DIGITS-1:0]   dp_mask;
  logic [DIGITS-1:0]   blink_mask;
  logic                busy;
  logic                frame_tick;

  modport master (
    output data_in, load, blank_lz, dp_mask, blink_mask,
    input  busy, frame_tick
  );

  modport slave (
    input  data_in, load, blank_lz, dp_mask, blink_mask,
    output busy, frame_tick
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph; zero latency, no flow control.
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (nib)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver with frame-synchronous double buffering, LZ blanking and blink.
// Pins lag the scan index by one cycle; loads are never refused, busy flags a pending frame swap.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 64
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_display_if.slave   host,
  output logic [DIGITS-1:0]   an,
  output seg_t                seg,
  output logic                dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] dat;
    logic [DIGITS-1:0]   dpm;
    logic [DIGITS-1:0]   blk;
  } disp_buf_t;

  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [FW-1:0] frm;
  logic          blink_phase;
  disp_buf_t     act_buf;
  disp_buf_t     pend_buf;
  logic          pend_vld;
  logic          tick_q;

  logic          boundary;
  logic [3:0]    cur_nib;
  logic          cur_dpm;
  logic          cur_blk;
  logic          zero_run;
  logic          zero_above;
  logic          blank;
  seg_t          cur_glyph;

  assign boundary        = (pre == PRE_LAST) && (idx == IDX_LAST);
  assign host.busy       = pend_vld;
  assign host.frame_tick = tick_q;

  // Walk from the top digit down so zero_above captures "all nibbles from the top to idx are 0".
  always_comb begin
    cur_nib    = 4'h0;
    cur_dpm    = 1'b0;
    cur_blk    = 1'b0;
    zero_run   = 1'b1;
    zero_above = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (act_buf.dat[4*k +: 4] != 4'h0) zero_run = 1'b0;
      if (IW'(k) == idx) begin
        cur_nib    = act_buf.dat[4*k +: 4];
        cur_dpm    = act_buf.dpm[k];
        cur_blk    = act_buf.blk[k];
        zero_above = zero_run;
      end
    end
  end

  assign blank = (host.blank_lz && (idx != '0) && zero_above) || (cur_blk && blink_phase);

  seg7_hex_decode u_dec (
    .nib   (cur_nib),
    .glyph (cur_glyph)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre         <= '0;
      idx         <= '0;
      frm         <= '0;
      blink_phase <= 1'b0;
      act_buf     <= '0;
      pend_buf    <= '0;
      pend_vld    <= 1'b0;
      tick_q      <= 1'b0;
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
    end else begin
      if (pre == PRE_LAST) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        pre <= pre + PW'(1);
      end

      tick_q <= boundary;

      if (boundary) begin
        if (pend_vld) act_buf <= pend_buf;
        if (frm == FRM_LAST) begin
          frm         <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frm <= frm + FW'(1);
        end
      end

      // A load on the boundary cycle wins over the clear, so its data waits one more frame.
      if (host.load) begin
        pend_buf <= '{dat: host.data_in, dpm: host.dp_mask, blk: host.blink_mask};
        pend_vld <= 1'b1;
      end else if (boundary) begin
        pend_vld <= 1'b0;
      end

      an  <= ~(DIGITS'(1) << idx);
      seg <= blank ? SEG_OFF : cur_glyph;
      dp  <= blank | ~cur_dpm;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIGITS=8, SCAN_DIV=4, BLINK_DIV=2.
module tb_seg_scan_display;

  logic       clk;
  logic       rst;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_tests;
  int n_fail;
  int fr;

  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_display_if #(.DIGITS(8)) bus ();

  seg_scan_display #(
    .DIGITS    (8),
    .SCAN_DIV  (4),
    .BLINK_DIV (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One full frame, digit 0 first; each sample packs {busy, frame_tick, an, seg, dp}.
  task automatic run_frame(input logic [31:0] act, input logic [7:0] dpm, input logic [7:0] blm,
                           input logic blz, input logic busy0,
                           input int a0, input logic [31:0] v0,
                           input int a1, input logic [31:0] v1,
                           input logic [7:0] ldp, input logic [7:0] lbl);
    logic       ph;
    logic [3:0] nib;
    logic       blnk;
    logic       ebusy;
    logic [6:0] eseg;
    logic       edp;
    logic [7:0] ean;
    int         d;
    ph = ((fr >> 1) & 1) != 0;
    bus.blank_lz = blz;
    for (int s = 0; s < 32; s++) begin
      @(negedge clk);
      d    = s / 4;
      nib  = act[4*d +: 4];
      blnk = (blz && d != 0 && (act >> (4*d)) == 32'h0) || (blm[d] && ph);
      eseg = blnk ? 7'h7F : gl[nib];
      edp  = blnk ? 1'b1 : ~dpm[d];
      ean  = ~(8'h01 << d);
      if (s == 31) ebusy = (a0 == 30) || (a1 == 30);
      else ebusy = busy0 || (a0 >= 0 && s > a0) || (a1 >= 0 && s > a1);
      chk($sformatf("frame%0d_s%0d", fr, s),
          32'({bus.busy, bus.frame_tick, an, seg, dp}),
          32'({ebusy, (s == 31), ean, eseg, edp}));
      bus.load = 1'b0;
      if (s == a0) begin
        bus.load = 1'b1; bus.data_in = v0; bus.dp_mask = ldp; bus.blink_mask = lbl;
      end
      if (s == a1) begin
        bus.load = 1'b1; bus.data_in = v1; bus.dp_mask = ldp; bus.blink_mask = lbl;
      end
    end
    fr++;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_an"},   32'(an),             32'hFF);
    chk({tag, "_seg"},  32'(seg),            32'h7F);
    chk({tag, "_dp"},   32'(dp),             32'h1);
    chk({tag, "_busy"}, 32'(bus.busy),       32'h0);
    chk({tag, "_tick"}, 32'(bus.frame_tick), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    fr      = 0;
    rst     = 1'b1;
    bus.data_in    = '0;
    bus.load       = 1'b0;
    bus.blank_lz   = 1'b0;
    bus.dp_mask    = '0;
    bus.blink_mask = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b1;

    // Plain scan, then a mid-frame load that shows up only after the boundary.
    run_frame(32'h0, 8'h00, 8'h00, 1'b0, 1'b0, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00);
    run_frame(32'h0, 8'h00, 8'h00, 1'b0, 1'b0, 10, 32'h1234ABCD, -1, 32'h0, 8'h00, 8'h00);
    run_frame(32'h1234ABCD, 8'h00, 8'h00, 1'b0, 1'b0, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00);

    // Back-to-back loads, then a pending load plus a load on the boundary cycle.
    run_frame(32'h1234ABCD, 8'h00, 8'h00, 1'b0, 1'b0, 5, 32'h11111111, 6, 32'h22222222, 8'h00, 8'h00);
    run_frame(32'h22222222, 8'h00, 8'h00, 1'b0, 1'b0, 5, 32'h44444444, 30, 32'h55555555, 8'h00, 8'h00);
    run_frame(32'h44444444, 8'h00, 8'h00, 1'b0, 1'b1, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00);
    run_frame(32'h55555555, 8'h00, 8'h00, 1'b0, 1'b0, 5, 32'h00000050, -1, 32'h0, 8'h00, 8'h00);

    // Leading-zero blanking on 0x50 and on all zeros.
    run_frame(32'h00000050, 8'h00, 8'h00, 1'b1, 1'b0, 5, 32'h0, -1, 32'h0, 8'h00, 8'h00);
    run_frame(32'h0, 8'h00, 8'h00, 1'b1, 1'b0, 5, 32'h76543210, -1, 32'h0, 8'h04, 8'h01);

    // Blink on digit 0 and decimal point on digit 2 across a full blink period.
    for (int i = 0; i < 4; i++)
      run_frame(32'h76543210, 8'h04, 8'h01, 1'b0, 1'b0, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00);

    // Reset mid-frame with a load pending: everything returns to reset values at once.
    repeat (3) @(negedge clk);
    bus.load    = 1'b1;
    bus.data_in = 32'hFFFFFFFF;
    @(negedge clk);
    bus.load = 1'b0;
    chk("pre_rst_busy", 32'(bus.busy), 32'h1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_state("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    fr  = 0;
    run_frame(32'h0, 8'h00, 8'h00, 1'b0, 1'b0, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment display driver for the washing-machine controller's front panel. It replaces the fixed 8-digit scan chain of counter, selector, 3-8 decoder and segment decoder with one block. It is configurable in digit count and scan rate, and adds:
- double-buffered frame-synchronous loading, so no torn frames are ever displayed;
- leading-zero blanking;
- per-digit blink;
- per-digit decimal points.

It sits between the controller FSM's display word and the board's `seg`/`an` pins.

## Interface
Parameters:
- `DIGITS`, default 8: number of digits, 2..16.
- `SCAN_DIV`, default 100000: clock cycles each digit is lit, ≥2.
- `BLINK_DIV`, default 64: complete frames per blink half-period, ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `data_in`, in, 4*DIGITS: hex nibbles. Nibble k drives digit k; digit 0 is rightmost.
- `load`, in, 1: one-cycle strobe that captures `data_in`, `dp_mask` and `blink_mask` into the pending buffer.
- `blank_lz`, in, 1: leading-zero blanking enable. Live input, not buffered.
- `dp_mask`, in, DIGITS: decimal point per digit. Buffered with `load`.
- `blink_mask`, in, DIGITS: blink enable per digit. Buffered with `load`.
- `busy`, out, 1: high while a pending load has not yet reached the active buffer.
- `frame_tick`, out, 1: one-cycle pulse at each frame boundary.
- `an`, out, DIGITS: digit enables, active-low, one-hot-low.
- `seg`, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`, out, 1: decimal point, active-low.

## Operation
- **Prescaler.** `pre` counts 0..SCAN_DIV-1. When `pre`==SCAN_DIV-1, `pre` wraps to 0 and scan index `idx` advances: `idx`+1, or 0 after DIGITS-1.
- **Frame boundary.** A frame boundary is the cycle with `pre`==SCAN_DIV-1 and `idx`==DIGITS-1. On that cycle:
  - `frame_tick` is asserted on the next cycle;
  - if the pending buffer is valid, active ← pending and the pending-valid flag is cleared;
  - the frame counter advances. It counts 0..BLINK_DIV-1 and `blink_phase` toggles when it wraps.
- **Load.** `load` writes the pending buffer and sets pending-valid in any cycle.
  - A second `load` before the transfer overwrites the pending buffer. Last write wins.
  - If `load` arrives on a frame-boundary cycle, the old pending contents transfer to active, the new data becomes pending, and `busy` stays 1 until the next boundary.
- **busy.** `busy` equals the pending-valid flag.
- **Digit blanking.** Digit k is blank when either of the following holds:
  - `blank_lz`=1, k≠0, and every active nibble from DIGITS-1 down to k is 0. Digit 0 is never blanked this way.
  - `blink_mask`[k]=1 and `blink_phase`=1.
- **Blank digit.** `seg`=7'h7F and `dp`=1, while `an`[k] is still driven low.
- **Non-blank digit.** `seg` is the hex glyph of nibble k, and `dp`=~`dp_mask`[k].
- **Glyph patterns** (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

## Timing
- **Reset values** (all outputs and state, applied asynchronously as soon as `rst`=0, including mid-frame):
  - `pre`=0, `idx`=0, frame counter=0, `blink_phase`=0;
  - active buffer=0, pending buffer=0, pending-valid=0;
  - `busy`=0, `frame_tick`=0, `an`=all 1s, `seg`=7'h7F, `dp`=1.
- **Registered outputs.** `an`/`seg`/`dp` are registered from the current `idx` and active buffer, so outputs lag `idx` by 1 cycle. The first digit is lit in the first clock after `rst` deasserts.
- **Dwell.** Each digit stays lit for exactly SCAN_DIV cycles. A frame is DIGITS×SCAN_DIV cycles.
- **Load latency.**
  - `busy` rises the cycle after `load`.
  - The new value first appears on `seg` at most DIGITS×SCAN_DIV+1 cycles after `load`, always at digit 0.
- **Blink period.** 2×BLINK_DIV frames.

## Structure
- Shared package `seg_pkg`:
  - glyph constants;
  - `SEG_OFF`=7'h7F;
  - the segment bit-order definition.
- Sub-module `seg7_hex_decode`: combinational nibble-to-glyph decoder, reused by other panels.
- Prescaler, scan index, buffers, blink and blanking logic all live in `seg_scan_display`.

## Test plan
All scenarios use DIGITS=8, SCAN_DIV=4 and BLINK_DIV=2.
1. **Reset and scan.** Release `rst` → `an` cycles FE, FD, … 7F, each for 4 cycles; `frame_tick` pulses every 32 cycles; `seg`=40 throughout. Assert `rst` mid-frame → outputs return to reset values immediately.
2. **Load timing.** `load` with `data_in`=32'h1234ABCD mid-frame → `busy`=1 until the boundary, display unchanged; the next frame shows D,C,b,A,4,3,2,1 (21,46,03,08,19,30,24,79).
3. **Load collision.** Back-to-back `load`s of 32'h11111111 then 32'h22222222, plus a `load` exactly on a boundary cycle → only the last value before each boundary is shown; on the boundary-cycle load, `busy` remains 1 for one more frame.
4. **Leading-zero blanking.** `blank_lz`=1, data 32'h00000050 → digits 7..2 show `seg`=7F, digit 1 shows 12, digit 0 shows 40. Data 0 → only digit 0 shows 40.
5. **Blink and decimal point.** `blink_mask`=8'h01 → digit 0 is blank for frames 2–3 and lit for frames 0–1, repeating. `dp_mask`=8'h04 → `dp`=0 only while `an`=FB.
